// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly scheduler.
// Holds the FSM state encoding and the index-to-bank/address mapping helpers.
// Purely declarative: no state, no timing.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Two indices differing in exactly one bit always land in opposite banks.
    function automatic logic bank_of(input logic [15:0] idx);
        return ^idx;
    endfunction

    // Word address inside the selected bank.
    function automatic logic [15:0] addr_of(input logic [15:0] idx);
        return idx >> 1;
    endfunction

endpackage

// File: rtl/ntt_sched_dly.sv
// Valid+payload shift register with an intermediate valid tap.
// Latency: DEPTH cycles to o_vld/o_dat, TAP cycles to o_tap_vld.
// No backpressure: shifts every cycle, o_any_vld reports any entry in flight.
module ntt_sched_dly #(
    parameter int DEPTH = 7,
    parameter int TAP   = 1,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_tap_vld,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_any_vld
);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_dat [DEPTH];

    // Element j holds the entry issued j+1 cycles ago.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                r_dat[j] <= '0;
            end
        end else begin
            r_vld    <= {r_vld[DEPTH-2:0], i_vld};
            r_dat[0] <= i_dat;
            for (int j = 1; j < DEPTH; j++) begin
                r_dat[j] <= r_dat[j-1];
            end
        end
    end

    assign o_tap_vld = r_vld[TAP-1];
    assign o_vld     = r_vld[DEPTH-1];
    assign o_dat     = r_dat[DEPTH-1];
    assign o_any_vld = |r_vld;

endmodule

// File: rtl/ntt_sched_ctrl.sv
// Stage/butterfly scheduler for an in-place radix-2 NTT/INTT, one butterfly per cycle.
// Latency: bfu_en RAM_LAT, wr_* RAM_LAT+BFU_LAT cycles after rd_en; each stage drains fully.
// Backpressure: i_hold stalls issue only; in-flight entries keep flowing to write-back.
module ntt_sched_ctrl
    import ntt_pkg::*;
#(
    parameter int LOG_N   = 8,
    parameter int RAM_LAT = 1,
    parameter int BFU_LAT = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_inv,
    input  logic             i_hold,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic             o_rd_set,
    output logic [LOG_N-2:0] o_rd_addr0,
    output logic [LOG_N-2:0] o_rd_addr1,
    output logic             o_rd_swap,
    output logic [LOG_N:0]   o_tw_addr,
    output logic             o_bfu_en,
    output logic             o_wr_en,
    output logic             o_wr_set,
    output logic [LOG_N-2:0] o_wr_addr0,
    output logic [LOG_N-2:0] o_wr_addr1,
    output logic             o_wr_swap
);

    localparam int AW     = LOG_N - 1;
    localparam int HALF_N = 1 << (LOG_N - 1);
    localparam int DLY    = RAM_LAT + BFU_LAT;
    localparam int PW     = 2 * AW + 2;
    localparam logic [AW-1:0] K_LAST     = AW'(HALF_N - 1);
    localparam logic [3:0]    LAST_STAGE = 4'(LOG_N - 1);

    state_t          r_state;
    logic [3:0]      r_stage;
    logic [AW-1:0]   r_k;
    logic            r_inv;

    logic             w_rd_en;
    logic             w_any_vld;
    logic [3:0]       w_h;
    logic [LOG_N-1:0] w_half;
    logic [LOG_N-1:0] w_grp;
    logic [LOG_N-1:0] w_off;
    logic [LOG_N-1:0] w_i0;
    logic [LOG_N-1:0] w_i1;
    logic [LOG_N-1:0] w_tw_idx;
    logic             w_swap;
    logic [AW-1:0]    w_a_i0;
    logic [AW-1:0]    w_a_i1;
    logic [PW-1:0]    w_rd_dat;
    logic [PW-1:0]    w_wr_dat;

    assign w_rd_en = (r_state == ST_RUN) && !i_hold;

    // Butterfly index pair, bank split and twiddle index for the current (s, k).
    always_comb begin
        w_h      = LAST_STAGE - r_stage;
        w_half   = LOG_N'(1) << w_h;
        w_grp    = LOG_N'(r_k) >> w_h;
        w_off    = LOG_N'(r_k) & (w_half - LOG_N'(1));
        w_i0     = (w_grp << (w_h + 4'd1)) + w_off;
        w_i1     = w_i0 + w_half;
        w_swap   = bank_of(16'(w_i0));
        w_a_i0   = AW'(addr_of(16'(w_i0)));
        w_a_i1   = AW'(addr_of(16'(w_i1)));
        w_tw_idx = (LOG_N'(1) << r_stage) + w_grp;
    end

    // Read-side fields are forced to zero whenever no butterfly is issued.
    always_comb begin
        o_rd_en    = w_rd_en;
        o_rd_set   = w_rd_en & r_stage[0];
        o_rd_swap  = w_rd_en & w_swap;
        o_rd_addr0 = '0;
        o_rd_addr1 = '0;
        o_tw_addr  = '0;
        if (w_rd_en) begin
            o_rd_addr0 = w_swap ? w_a_i1 : w_a_i0;
            o_rd_addr1 = w_swap ? w_a_i0 : w_a_i1;
            o_tw_addr  = {r_inv, w_tw_idx};
        end
    end

    assign w_rd_dat = {o_rd_set, o_rd_addr0, o_rd_addr1, o_rd_swap};

    ntt_sched_dly #(
        .DEPTH (DLY),
        .TAP   (RAM_LAT),
        .WIDTH (PW)
    ) u_dly (
        .i_clk     (i_clk),
        .i_rst_n   (i_reset),
        .i_vld     (w_rd_en),
        .i_dat     (w_rd_dat),
        .o_tap_vld (o_bfu_en),
        .o_vld     (o_wr_en),
        .o_dat     (w_wr_dat),
        .o_any_vld (w_any_vld)
    );

    assign {o_wr_set, o_wr_addr0, o_wr_addr1, o_wr_swap} = w_wr_dat;

    // Stage/butterfly sequencing; a stage starts only once the previous one has fully written back.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_inv   <= i_inv;
                        r_stage <= '0;
                        r_k     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_rd_en) begin
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_k <= r_k + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_any_vld) begin
                        if (r_stage == LAST_STAGE) begin
                            r_stage <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_stage <= r_stage + 4'd1;
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (r_state == ST_IDLE);
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_ntt_sched_ctrl.sv
// Directed bench for ntt_sched_ctrl at LOG_N=3, with default and short latencies.
// Checks addresses, twiddles, cycle counts, hold, inv latching, abort and write-back alignment.
// Inputs driven 1 time unit after posedge, outputs sampled 2 units after posedge.
module tb_ntt_sched_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start1, inv1, hold1;
    logic start2, inv2, hold2;

    logic       ready1, busy1, done1, rd_en1, rd_set1, rd_swap1, bfu1, wr_en1, wr_set1, wr_swap1;
    logic [1:0] rd_a0_1, rd_a1_1, wr_a0_1, wr_a1_1;
    logic [3:0] tw1;
    logic       ready2, busy2, done2, rd_en2, rd_set2, rd_swap2, bfu2, wr_en2, wr_set2, wr_swap2;
    logic [1:0] rd_a0_2, rd_a1_2, wr_a0_2, wr_a1_2;
    logic [3:0] tw2;

    ntt_sched_ctrl #(.LOG_N(3), .RAM_LAT(1), .BFU_LAT(6)) u_dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start1), .i_inv(inv1), .i_hold(hold1),
        .o_ready(ready1), .o_busy(busy1), .o_done(done1), .o_rd_en(rd_en1), .o_rd_set(rd_set1),
        .o_rd_addr0(rd_a0_1), .o_rd_addr1(rd_a1_1), .o_rd_swap(rd_swap1), .o_tw_addr(tw1),
        .o_bfu_en(bfu1), .o_wr_en(wr_en1), .o_wr_set(wr_set1), .o_wr_addr0(wr_a0_1),
        .o_wr_addr1(wr_a1_1), .o_wr_swap(wr_swap1)
    );

    ntt_sched_ctrl #(.LOG_N(3), .RAM_LAT(2), .BFU_LAT(1)) u_dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start2), .i_inv(inv2), .i_hold(hold2),
        .o_ready(ready2), .o_busy(busy2), .o_done(done2), .o_rd_en(rd_en2), .o_rd_set(rd_set2),
        .o_rd_addr0(rd_a0_2), .o_rd_addr1(rd_a1_2), .o_rd_swap(rd_swap2), .o_tw_addr(tw2),
        .o_bfu_en(bfu2), .o_wr_en(wr_en2), .o_wr_set(wr_set2), .o_wr_addr0(wr_a0_2),
        .o_wr_addr1(wr_a1_2), .o_wr_swap(wr_swap2)
    );

    int checks   = 0;
    int failures = 0;

    // Hand-derived issue order for N=8: {set, swap, addr0[1:0], addr1[1:0], tw_idx[2:0]}.
    localparam logic [8:0] EXP [12] = '{
        9'b0_0_00_10_001, 9'b0_1_10_00_001, 9'b0_1_11_01_001, 9'b0_0_01_11_001,
        9'b1_0_00_01_010, 9'b1_1_01_00_010, 9'b1_1_11_10_011, 9'b1_0_10_11_011,
        9'b0_0_00_00_100, 9'b0_1_01_01_101, 9'b0_1_10_10_110, 9'b0_0_11_11_111
    };

    logic [8:0] ev    [16];
    logic [5:0] wr_ev [16];
    int         n_ev, n_wr, n_bfu, n_msb;
    logic       hold_bfu;
    int         done_cyc;
    logic [8:0] e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transform on dut1, logging every issued read, bfu pulse and write-back.
    task automatic run1(input int hold_at, input logic inv_v, input int tog_at,
                        input int busy_start_at, output int dcyc);
        n_ev = 0; n_wr = 0; n_bfu = 0; n_msb = 0; hold_bfu = 1'b0; dcyc = -1;
        @(posedge clk); #1;
        start1 = 1'b1; inv1 = inv_v; hold1 = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            start1 = (c == busy_start_at);
            hold1  = (c >= hold_at) && (c < hold_at + 3);
            if (c == tog_at) inv1 = ~inv1;
            #1;
            if (rd_en1) begin
                if (n_ev < 16) ev[n_ev] = {rd_set1, rd_swap1, rd_a0_1, rd_a1_1, tw1[2:0]};
                if (tw1[3]) n_msb++;
                n_ev++;
            end
            if (bfu1) n_bfu++;
            if (wr_en1) begin
                if (n_wr < 16) wr_ev[n_wr] = {wr_set1, wr_a0_1, wr_a1_1, wr_swap1};
                n_wr++;
            end
            if (c == hold_at) hold_bfu = bfu1;
            if (done1) begin
                dcyc = c;
                break;
            end
        end
        start1 = 1'b0; hold1 = 1'b0;
    endtask

    initial begin
        logic [5:0] q_dat [$];
        int         q_cyc [$];
        int         n_rd2, n_wr2, n_done;
        logic [5:0] pd;
        int         pc;

        rst_n = 1'b0;
        start1 = 1'b0; inv1 = 1'b0; hold1 = 1'b0;
        start2 = 1'b0; inv2 = 1'b0; hold2 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", ready1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_rd_en", rd_en1, 0);
        chk("rst_rd_addr1", rd_a1_1, 0);
        chk("rst_tw", tw1, 0);
        chk("rst_bfu", bfu1, 0);
        chk("rst_wr_en", wr_en1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain NTT with a stray start while busy.
        run1(1000, 1'b0, 1000, 6, done_cyc);
        chk("ntt_done_cycle", done_cyc, 37);
        chk("ntt_n_rd", n_ev, 12);
        chk("ntt_n_bfu", n_bfu, 12);
        chk("ntt_n_wr", n_wr, 12);
        chk("ntt_tw_msb", n_msb, 0);
        for (int i = 0; i < 12; i++) begin
            e = EXP[i];
            chk($sformatf("ntt_rd%0d", i), ev[i], e);
            chk($sformatf("ntt_wr%0d", i), wr_ev[i], {e[8], e[6:5], e[4:3], e[7]});
        end
        @(posedge clk); #2;
        chk("ntt_ready_after", ready1, 1);
        chk("ntt_done_one_cycle", done1, 0);

        // Three hold cycles in stage 0.
        run1(2, 1'b0, 1000, 1000, done_cyc);
        chk("hold_done_cycle", done_cyc, 40);
        chk("hold_bfu_flows", hold_bfu, 1);
        chk("hold_n_rd", n_ev, 12);
        chk("hold_n_wr", n_wr, 12);
        for (int i = 0; i < 12; i++) begin
            e = EXP[i];
            chk($sformatf("hold_rd%0d", i), ev[i], e);
        end
        @(posedge clk);

        // INTT with inv toggled mid-run.
        run1(1000, 1'b1, 10, 1000, done_cyc);
        chk("intt_done_cycle", done_cyc, 37);
        chk("intt_tw_msb", n_msb, 12);
        chk("intt_rd0", ev[0], EXP[0]);
        chk("intt_rd11", ev[11], EXP[11]);
        inv1 = 1'b0;
        @(posedge clk);

        // Reset during stage 1 aborts with no done.
        @(posedge clk); #1;
        start1 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
        end
        #1;
        chk("abort_pre_rd_en", rd_en1, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready1, 1);
        chk("abort_busy", busy1, 0);
        chk("abort_rd_en", rd_en1, 0);
        chk("abort_bfu", bfu1, 0);
        chk("abort_wr_en", wr_en1, 0);
        chk("abort_tw", tw1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #2;
            if (done1) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_idle_ready", ready1, 1);

        // Short latencies: every write-back must mirror its read exactly 3 cycles later.
        n_rd2 = 0; n_wr2 = 0; done_cyc = -1;
        @(posedge clk); #1;
        start2 = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            #1;
            if (rd_en2) begin
                e = EXP[n_rd2 % 12];
                chk($sformatf("lat_rd%0d", n_rd2), {rd_set2, rd_swap2, rd_a0_2, rd_a1_2, tw2[2:0]}, e);
                q_dat.push_back({rd_set2, rd_a0_2, rd_a1_2, rd_swap2});
                q_cyc.push_back(c);
                n_rd2++;
            end
            if (wr_en2) begin
                if (q_dat.size() == 0) begin
                    chk("lat_wr_orphan", q_dat.size(), 1);
                end else begin
                    pd = q_dat.pop_front();
                    pc = q_cyc.pop_front();
                    chk($sformatf("lat_wr%0d_dat", n_wr2), {wr_set2, wr_a0_2, wr_a1_2, wr_swap2}, pd);
                    chk($sformatf("lat_wr%0d_dly", n_wr2), c - pc, 3);
                end
                n_wr2++;
            end
            if (done2) begin
                done_cyc = c;
                break;
            end
        end
        chk("lat_done_cycle", done_cyc, 25);
        chk("lat_n_rd", n_rd2, 12);
        chk("lat_n_wr", n_wr2, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
